// File: rtl/rr_arbiter.sv
// rr_arbiter: N-way arbiter with a registered one-hot grant.
// Round-robin or fixed priority; a held grant is bounded by MAX_HOLD.
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   req         level-sensitive request vector, one bit per requester
//   grant       registered one-hot grant, zero when idle
//   grant_valid high when any grant bit is set
//   grant_idx   binary index of the granted requester, zero when idle
module rr_arbiter #(
    parameter int N         = 8,
    parameter int MAX_HOLD  = 16,
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int IW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0] HOLD_LAST =
        HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [N-1:0]  ONE      = N'(1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        state;
    logic [HW-1:0] hold_cnt;
    logic [IW-1:0] ptr;

    logic [N-1:0]  cand;
    logic [IW-1:0] start;
    logic [IW-1:0] idx;
    logic [IW-1:0] win;
    logic          found;
    logic          owner_req;
    logic          others;
    logic          at_limit;
    logic          expired;

    assign owner_req = |(req & grant);
    assign others    = |(req & ~grant);
    assign at_limit  = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    assign expired   = at_limit && others;

    // Masking the current owner is harmless on release (its bit is
    // already low) and in IDLE (grant is zero), so one candidate set
    // serves every arbitration case.
    assign cand  = req & ~grant;
    assign start = FIXED_PRI ? '0 : ptr;

    // Circular search from start; the index wraps by compare so that
    // non-power-of-two N never reaches an unused code.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = start;
        for (int i = 0; i < N; i++) begin
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
            idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            hold_cnt    <= '0;
            ptr         <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        state       <= GRANT;
                        grant       <= ONE << win;
                        grant_valid <= 1'b1;
                        grant_idx   <= win;
                        hold_cnt    <= '0;
                        ptr         <= (win == LAST_IDX) ? '0 : win + 1'b1;
                    end
                end
                GRANT: begin
                    if ((!owner_req || expired) && found) begin
                        grant       <= ONE << win;
                        grant_valid <= 1'b1;
                        grant_idx   <= win;
                        hold_cnt    <= '0;
                        ptr         <= (win == LAST_IDX) ? '0 : win + 1'b1;
                    end else if (!owner_req) begin
                        state       <= IDLE;
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        grant_idx   <= '0;
                        hold_cnt    <= '0;
                    end else if (MAX_HOLD == 0 || at_limit) begin
                        // Lone owner at the limit keeps the grant and
                        // starts a fresh hold window.
                        hold_cnt    <= '0;
                    end else begin
                        hold_cnt    <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: vector table, fixed-mode sequence and random run
// against a reference model for two rr_arbiter configurations.
module tb_rr_arbiter;

    logic       clk;
    logic       rst_a;
    logic [7:0] req_a;
    logic [7:0] g_a;
    logic       v_a;
    logic [2:0] i_a;
    logic       rst_b;
    logic [7:0] req_b;
    logic [7:0] g_b;
    logic       v_b;
    logic [2:0] i_b;

    int total = 0;
    int bad   = 0;

    rr_arbiter #(.N(8), .MAX_HOLD(4), .FIXED_PRI(1'b0)) dut_a (
        .clk         (clk),
        .reset       (rst_a),
        .req         (req_a),
        .grant       (g_a),
        .grant_valid (v_a),
        .grant_idx   (i_a)
    );

    rr_arbiter #(.N(8), .MAX_HOLD(0), .FIXED_PRI(1'b1)) dut_b (
        .clk         (clk),
        .reset       (rst_b),
        .req         (req_b),
        .grant       (g_b),
        .grant_valid (v_b),
        .grant_idx   (i_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] exp;
    } vec_t;

    vec_t tv[$];

    function automatic void add(logic r, logic [7:0] q, logic [7:0] e);
        vec_t v;
        v.rst = r;
        v.req = q;
        v.exp = e;
        tv.push_back(v);
    endfunction

    // Reference model: owner index (-1 = idle), cycles held, next start.
    int m_owner[2];
    int m_held[2];
    int m_ptr[2];

    task automatic model_step(int u, logic rst, logic [7:0] r);
        int         maxh;
        int         st;
        int         k;
        bit         pick;
        bit         done;
        logic [7:0] pool;
        maxh = (u == 0) ? 4 : 0;
        pick = 1'b0;
        pool = r;
        if (rst) begin
            m_owner[u] = -1;
            m_held[u]  = 0;
            m_ptr[u]   = 0;
        end else begin
            if (m_owner[u] < 0) begin
                pick = (r != 0);
            end else if (!r[m_owner[u]]) begin
                if (r == 0) m_owner[u] = -1;
                else pick = 1'b1;
            end else if (maxh != 0 && m_held[u] == maxh - 1) begin
                pool = r & ~(8'd1 << m_owner[u]);
                if (pool != 0) pick = 1'b1;
                else m_held[u] = 0;
            end else begin
                m_held[u] = m_held[u] + 1;
            end
            if (pick) begin
                st   = (u == 1) ? 0 : m_ptr[u];
                done = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    k = (st + i) % 8;
                    if (!done && pool[k]) begin
                        done       = 1'b1;
                        m_owner[u] = k;
                        m_held[u]  = 0;
                        m_ptr[u]   = (k + 1) % 8;
                    end
                end
            end
        end
    endtask

    function automatic logic [7:0] model_grant(int u);
        if (m_owner[u] < 0) return 8'h00;
        return 8'd1 << m_owner[u];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string nm, logic [7:0] g, logic v,
                         logic [2:0] ix, logic [7:0] e);
        logic [2:0] eix;
        logic       ev;
        eix = '0;
        for (int i = 0; i < 8; i++)
            if (e[i]) eix = 3'(i);
        ev = (e != 8'h00);
        total++;
        if (g !== e || v !== ev || ix !== eix) begin
            bad++;
            $display("FAIL %s: grant=%h valid=%b idx=%0d want grant=%h valid=%b idx=%0d",
                     nm, g, v, ix, e, ev, eix);
        end
    endtask

    initial begin
        clk   = 1'b0;
        rst_a = 1'b1;
        req_a = 8'h00;
        rst_b = 1'b1;
        req_b = 8'h00;

        // reset with all requesting, then first grant
        add(1, 8'hFF, 8'h00);
        add(1, 8'hFF, 8'h00);
        add(0, 8'hFF, 8'h01);
        // round-robin rotation, owner drops for one cycle
        add(1, 8'h16, 8'h00);
        add(0, 8'h16, 8'h02);
        add(0, 8'h14, 8'h04);
        add(0, 8'h12, 8'h10);
        add(0, 8'h06, 8'h02);
        add(0, 8'h16, 8'h02);
        // hold expiry, 4 cycles each
        add(1, 8'h03, 8'h00);
        for (int i = 0; i < 4; i++) add(0, 8'h03, 8'h01);
        for (int i = 0; i < 4; i++) add(0, 8'h03, 8'h02);
        add(0, 8'h03, 8'h01);
        for (int i = 0; i < 22; i++) add(0, 8'h01, 8'h01);
        // release to idle and pointer wrap
        add(1, 8'h00, 8'h00);
        add(0, 8'h01, 8'h01);
        add(0, 8'h80, 8'h80);
        add(0, 8'h00, 8'h00);
        add(0, 8'h81, 8'h01);
        // reset mid-grant restores pointer
        add(1, 8'h00, 8'h00);
        add(0, 8'h08, 8'h08);
        add(0, 8'h08, 8'h08);
        add(1, 8'h18, 8'h00);
        add(0, 8'h18, 8'h08);

        foreach (tv[i]) begin
            rst_a = tv[i].rst;
            req_a = tv[i].req;
            step();
            check($sformatf("vec%0d", i), g_a, v_a, i_a, tv[i].exp);
        end

        // fixed priority, no hold limit
        rst_b = 1'b1;
        req_b = 8'h00;
        step();
        check("fix_reset", g_b, v_b, i_b, 8'h00);
        rst_b = 1'b0;
        req_b = 8'hA0;
        step();
        check("fix_first", g_b, v_b, i_b, 8'h20);
        req_b = 8'hA1;
        step();
        check("fix_nopreempt1", g_b, v_b, i_b, 8'h20);
        step();
        check("fix_nopreempt2", g_b, v_b, i_b, 8'h20);
        req_b = 8'h81;
        step();
        check("fix_release", g_b, v_b, i_b, 8'h01);
        req_b = 8'hFF;
        for (int i = 0; i < 30; i++) begin
            step();
            check("fix_unlimited", g_b, v_b, i_b, 8'h01);
        end
        req_b = 8'hFE;
        step();
        check("fix_next", g_b, v_b, i_b, 8'h02);

        // random run against the model, occasional resets
        rst_a = 1'b1;
        rst_b = 1'b1;
        req_a = 8'h00;
        req_b = 8'h00;
        step();
        model_step(0, 1'b1, 8'h00);
        model_step(1, 1'b1, 8'h00);
        for (int n = 0; n < 3000; n++) begin
            rst_a = ($urandom_range(0, 99) == 0);
            rst_b = ($urandom_range(0, 99) == 0);
            req_a = req_a ^ 8'($urandom & $urandom);
            req_b = req_b ^ 8'($urandom & $urandom);
            step();
            model_step(0, rst_a, req_a);
            model_step(1, rst_b, req_b);
            check($sformatf("rand_a%0d", n), g_a, v_a, i_a, model_grant(0));
            check($sformatf("rand_b%0d", n), g_b, v_b, i_b, model_grant(1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
